// File: rtl/pulse_sync_gc_rx_mc_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sync_pkg
// Shared helpers for the multi-channel Gray-code pulse-count receiver.
//   gray2bin / bin2gray : Gray <-> binary conversion. Both work on a 32-bit
//                         container. A narrower code is zero-extended on the
//                         way in and truncated on the way out, and this gives
//                         the correct result for any width up to 32.
//   STAT_WIDTH          : width of the optional accepted-pulse counters
// -----------------------------------------------------------------------------
package pulse_sync_pkg;

  localparam int STAT_WIDTH = 32;
  localparam int GC_MAX_W   = 32;

  function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] g);
    logic [GC_MAX_W-1:0] b;
    b[GC_MAX_W-1] = g[GC_MAX_W-1];
    for (int i = GC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pulse_sync_gc_rx_mc_if.sv
// -----------------------------------------------------------------------------
// pulse_sync_gc_rx_mc_if
// Bundles the per-channel signals of the Gray-code pulse receiver.
//   gc_in      : Gray counters from the source domain
//   dout_valid : channel has at least one pending pulse
//   dout_ready : consumer accepts one pulse this cycle
//   ovf        : sticky backlog-saturation flag
//   ovf_clr    : one-cycle clear of ovf
//   primed     : start-up priming complete
//   stat_cnt / stat_clr : accepted-pulse counters. These exist only when
//                         PULSE_SYNC_GC_STATS_EN is defined.
// modport master = receiver side, modport slave = source/consumer side.
// -----------------------------------------------------------------------------
interface pulse_sync_gc_rx_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int CNTR_WIDTH = 3
);
  import pulse_sync_pkg::*;

  logic [NUM_CH-1:0][CNTR_WIDTH-1:0] gc_in;
  logic [NUM_CH-1:0]                 dout_valid;
  logic [NUM_CH-1:0]                 dout_ready;
  logic [NUM_CH-1:0]                 ovf;
  logic [NUM_CH-1:0]                 ovf_clr;
  logic                              primed;
`ifdef PULSE_SYNC_GC_STATS_EN
  logic [NUM_CH-1:0][STAT_WIDTH-1:0] stat_cnt;
  logic                              stat_clr;
`endif

  modport master (
    input  gc_in, dout_ready, ovf_clr,
`ifdef PULSE_SYNC_GC_STATS_EN
    input  stat_clr,
    output stat_cnt,
`endif
    output dout_valid, ovf, primed
  );

  modport slave (
    output gc_in, dout_ready, ovf_clr,
`ifdef PULSE_SYNC_GC_STATS_EN
    output stat_clr,
    input  stat_cnt,
`endif
    input  dout_valid, ovf, primed
  );

endinterface

// File: rtl/pulse_sync_gc_rx_mc_ch.sv
// -----------------------------------------------------------------------------
// pulse_sync_gc_rx_ch
// One receive channel. It contains the Gray synchroniser chain, the decoder,
// the modular delta, the saturating backlog with sticky overflow, and an
// optional accepted-pulse counter (PULSE_SYNC_GC_STATS_EN).
//   clk_out, resetn : destination clock and synchronous active-low reset
//   primed          : from the top. While low, deltas are discarded.
//   gc_in           : asynchronous Gray count
//   dout_valid/ready: pulse handshake
//   ovf / ovf_clr   : sticky overflow flag and its clear
//   stat_clr/stat_cnt (optional) : counter clear and accepted-pulse count
// -----------------------------------------------------------------------------
module pulse_sync_gc_rx_ch
  import pulse_sync_pkg::*;
#(
  parameter int CNTR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int BACKLOG_WIDTH = 8
) (
  input  logic                  clk_out,
  input  logic                  resetn,
  input  logic                  primed,
  input  logic [CNTR_WIDTH-1:0] gc_in,
  input  logic                  dout_ready,
  input  logic                  ovf_clr,
`ifdef PULSE_SYNC_GC_STATS_EN
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_cnt,
`endif
  output logic                  dout_valid,
  output logic                  ovf
);

  localparam logic [BACKLOG_WIDTH:0] SUM_MAX = (BACKLOG_WIDTH+1)'((1 << BACKLOG_WIDTH) - 1);

  logic [SYNC_STAGES-1:0][CNTR_WIDTH-1:0] sync_q, sync_d;
  logic [CNTR_WIDTH-1:0]    bin, bin_prev_q, bin_prev_d, delta, delta_acc;
  logic [BACKLOG_WIDTH-1:0] backlog_q, backlog_d;
  logic [BACKLOG_WIDTH:0]   sum;
  logic                     ovf_q, ovf_d, ovf_set, take;

  always_comb begin
    sync_d[0] = gc_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign bin        = CNTR_WIDTH'(gray2bin(GC_MAX_W'(sync_q[SYNC_STAGES-1])));
  assign dout_valid = (backlog_q != '0);
  assign take       = dout_valid & dout_ready;
  assign ovf        = ovf_q;

  always_comb begin
    bin_prev_d = bin;
    // Modular subtraction absorbs wrap of the source counter.
    delta      = bin - bin_prev_q;
    delta_acc  = primed ? delta : '0;
    // take is only possible with backlog >= 1, so this cannot underflow.
    sum        = {1'b0, backlog_q} + (BACKLOG_WIDTH+1)'(delta_acc)
                 - (BACKLOG_WIDTH+1)'(take);
    ovf_set    = (sum > SUM_MAX);
    backlog_d  = ovf_set ? {BACKLOG_WIDTH{1'b1}} : sum[BACKLOG_WIDTH-1:0];
    // Set wins over a same-cycle clear.
    ovf_d      = ovf_set | (ovf_q & ~ovf_clr);
  end

`ifdef PULSE_SYNC_GC_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q, stat_d;
  // A take that coincides with the clear is deliberately not counted.
  assign stat_d   = stat_clr ? '0 : stat_q + STAT_WIDTH'(take);
  assign stat_cnt = stat_q;

  always_ff @(posedge clk_out) begin
    if (!resetn) stat_q <= '0;
    else         stat_q <= stat_d;
  end
`endif

  always_ff @(posedge clk_out) begin
    if (!resetn) begin
      sync_q     <= '0;
      bin_prev_q <= '0;
      backlog_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      bin_prev_q <= bin_prev_d;
      backlog_q  <= backlog_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: rtl/pulse_sync_gc_rx_mc.sv
// -----------------------------------------------------------------------------
// pulse_sync_gc_rx_mc
// Receive side of a multi-channel Gray-code pulse-count crossing. Each channel
// turns the count delta of its source into a backlog, and the backlog is
// drained as a valid/ready pulse stream. This level holds only the shared
// start-up fill counter and the primed flag.
//   clk_out : destination clock
//   resetn  : synchronous active-low reset
//   bus     : pulse_sync_gc_rx_mc_if.master (gc_in, dout_valid/ready, ovf,
//             ovf_clr, primed, and the optional stat_cnt/stat_clr)
// Optional feature macro: PULSE_SYNC_GC_STATS_EN (per-channel accepted-pulse counters).
// -----------------------------------------------------------------------------
module pulse_sync_gc_rx_mc
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNTR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int BACKLOG_WIDTH = 8
) (
  input  logic                   clk_out,
  input  logic                   resetn,
  pulse_sync_gc_rx_mc_if.master  bus
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 2);

  logic [FILL_W-1:0] fill_q, fill_d;
  logic              primed_q, primed_d;
  logic [NUM_CH-1:0] valid_w, ovf_w;

  // The fill counter runs SYNC_STAGES+1 cycles after reset release. This lets
  // the chain and bin_prev settle on post-reset samples, so the source's
  // pre-reset count is never turned into pulses.
  always_comb begin
    fill_d   = fill_q;
    primed_d = primed_q;
    if (!primed_q) begin
      fill_d = fill_q + FILL_W'(1);
      if (fill_q == FILL_W'(SYNC_STAGES)) primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_out) begin
    if (!resetn) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      primed_q <= primed_d;
    end
  end

`ifdef PULSE_SYNC_GC_STATS_EN
  logic [NUM_CH-1:0][STAT_WIDTH-1:0] stat_w;
  assign bus.stat_cnt = stat_w;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pulse_sync_gc_rx_ch #(
        .CNTR_WIDTH    (CNTR_WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .BACKLOG_WIDTH (BACKLOG_WIDTH)
      ) u_ch (
        .clk_out    (clk_out),
        .resetn     (resetn),
        .primed     (primed_q),
        .gc_in      (bus.gc_in[gi]),
        .dout_ready (bus.dout_ready[gi]),
        .ovf_clr    (bus.ovf_clr[gi]),
`ifdef PULSE_SYNC_GC_STATS_EN
        .stat_clr   (bus.stat_clr),
        .stat_cnt   (stat_w[gi]),
`endif
        .dout_valid (valid_w[gi]),
        .ovf        (ovf_w[gi])
      );
    end
  endgenerate

  assign bus.dout_valid = valid_w;
  assign bus.ovf        = ovf_w;
  assign bus.primed     = primed_q;

endmodule

// File: tb/tb_pulse_sync_gc_rx_mc.sv
module tb_pulse_sync_gc_rx_mc;
  localparam int NC = 4;
  localparam int CW = 3;
  localparam int SS = 2;
  localparam int BW = 4;
  localparam int BL_MAX = (1 << BW) - 1;
  localparam int CMOD = 1 << CW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pulse_sync_gc_rx_mc_if #(.NUM_CH(NC), .CNTR_WIDTH(CW)) bus ();

  pulse_sync_gc_rx_mc #(
    .NUM_CH(NC), .CNTR_WIDTH(CW), .SYNC_STAGES(SS), .BACKLOG_WIDTH(BW)
  ) dut (
    .clk_out (clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model. It tracks the source counts, what was sampled at each
  // edge since reset release, and the pulses owed to each consumer.
  int          src_cnt [NC];
  int          hist    [NC][64];
  int          n_edges = 0;
  int          m_backlog [NC];
  bit          m_ovf [NC];
  int unsigned m_stat [NC];

  function automatic logic [CW-1:0] to_gray(input int v);
    logic [CW-1:0] b;
    b = v[CW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic set_src(input int c, input int v);
    src_cnt[c] = v % CMOD;
    bus.gc_in[c] = to_gray(src_cnt[c]);
  endtask

  task automatic model_edge();
    int d, nb;
    bit tk;
    if (!resetn) begin
      n_edges = 0;
      for (int c = 0; c < NC; c++) begin
        m_backlog[c] = 0; m_ovf[c] = 0; m_stat[c] = 0;
      end
    end else begin
      n_edges++;
      for (int c = 0; c < NC; c++) begin
        hist[c][n_edges % 64] = src_cnt[c];
        // A count seen at edge k turns into pulses SS edges later. The first
        // SS+1 edges after release only prime.
        if (n_edges >= SS + 2)
          d = (hist[c][(n_edges - SS) % 64] - hist[c][(n_edges - SS - 1) % 64] + CMOD) % CMOD;
        else
          d = 0;
        tk = (m_backlog[c] != 0) && bus.dout_ready[c];
        nb = m_backlog[c] + d - int'(tk);
        if (nb > BL_MAX) begin
          nb = BL_MAX; m_ovf[c] = 1'b1;
        end else if (bus.ovf_clr[c]) begin
          m_ovf[c] = 1'b0;
        end
        m_backlog[c] = nb;
`ifdef PULSE_SYNC_GC_STATS_EN
        if (bus.stat_clr) m_stat[c] = 0;
        else if (tk)      m_stat[c] = m_stat[c] + 1;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.dout_ready = '0;
    bus.ovf_clr = '0;
`ifdef PULSE_SYNC_GC_STATS_EN
    bus.stat_clr = 1'b0;
`endif
    for (int c = 0; c < NC; c++) set_src(c, 0);
    set_src(0, 6);  // Gray 3'b101
    repeat (3) tick();
    vectors++;
    if (bus.dout_valid !== '0 || bus.ovf !== '0 || bus.primed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b ovf=%b primed=%b required 0/0/0",
               bus.dout_valid, bus.ovf, bus.primed);
    end
    resetn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      vectors++;
      if (bus.primed !== (i >= SS + 1)) begin
        miscompares++;
        $display("FAIL priming cycle %0d: primed=%b required %b", i, bus.primed, (i >= SS + 1));
      end
      vectors++;
      if (bus.dout_valid[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL priming_no_valid cycle %0d: dout_valid[0]=%b required 0", i, bus.dout_valid[0]);
      end
    end
  endtask

  task automatic test_burst();
    int high;
    resetn = 1'b0;
    set_src(0, 0);
    set_src(1, 6);
    tick();
    resetn = 1'b1;
    repeat (4) tick();
    bus.dout_ready[0] = 1'b1;
    high = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) set_src(0, i + 1);  // Gray 0->1->3->2
      tick();
      if (bus.dout_valid[0] === 1'b1) high++;
      vectors++;
      if (bus.dout_valid[0] !== (m_backlog[0] != 0)) begin
        miscompares++;
        $display("FAIL burst cycle %0d: dout_valid[0]=%b required %b", i, bus.dout_valid[0], (m_backlog[0] != 0));
      end
    end
    vectors++;
    if (high != 3) begin
      miscompares++;
      $display("FAIL burst_count: valid cycles=%0d required 3", high);
    end
    bus.dout_ready[0] = 1'b0;
  endtask

  task automatic test_wrap_backpressure();
    bus.dout_ready[1] = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      set_src(1, i);  // bin 6->7->0->1
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.dout_valid[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_take %0d: dout_valid[1]=%b required 1", i, bus.dout_valid[1]);
      end
      bus.dout_ready[1] = 1'b1;
      tick();
    end
    bus.dout_ready[1] = 1'b0;
    vectors++;
    if (bus.dout_valid[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_drained: dout_valid[1]=%b required 0", bus.dout_valid[1]);
    end
  endtask

  task automatic test_overflow();
    int drained;
    bus.dout_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_src(0, src_cnt[0] + 4);
      tick();
    end
    repeat (3) tick();
    vectors++;
    if (bus.ovf[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: ovf[0]=%b required 1", bus.ovf[0]);
    end
    set_src(0, src_cnt[0] + 1);
    tick(); tick();
    bus.ovf_clr[0] = 1'b1;  // coincides with the delta landing
    tick();
    bus.ovf_clr[0] = 1'b0;
    vectors++;
    if (bus.ovf[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_priority: ovf[0]=%b required 1", bus.ovf[0]);
    end
    bus.ovf_clr[0] = 1'b1;
    tick();
    bus.ovf_clr[0] = 1'b0;
    vectors++;
    if (bus.ovf[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf[0]=%b required 0", bus.ovf[0]);
    end
    bus.dout_ready[0] = 1'b1;
    drained = 0;
    for (int i = 0; i < 40 && bus.dout_valid[0] === 1'b1; i++) begin
      tick();
      drained++;
    end
    bus.dout_ready[0] = 1'b0;
    vectors++;
    if (drained != BL_MAX) begin
      miscompares++;
      $display("FAIL ovf_saturated_backlog: drained=%0d required %0d", drained, BL_MAX);
    end
  endtask

  task automatic test_simultaneous();
    bit exp_seq [3] = '{1'b1, 1'b1, 1'b0};
    bus.dout_ready[3] = 1'b0;
    set_src(3, src_cnt[3] + 1);
    repeat (3) tick();
    set_src(3, src_cnt[3] + 2);
    tick(); tick();
    bus.dout_ready[3] = 1'b1;  // take and delta 2 land on the same edge
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.dout_valid[3] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL simultaneous step %0d: dout_valid[3]=%b required %b", i, bus.dout_valid[3], exp_seq[i]);
      end
    end
    bus.dout_ready = '0;
    set_src(0, src_cnt[0] + 5);
    set_src(2, src_cnt[2] + 3);
    repeat (3) tick();
    vectors++;
    if (bus.dout_valid[0] !== 1'b1 || bus.dout_valid[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_pending: dout_valid=%b required ch0,ch2 high", bus.dout_valid);
    end
    resetn = 1'b0;
    tick();
    vectors++;
    if (bus.dout_valid !== '0 || bus.ovf !== '0 || bus.primed !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: valid=%b ovf=%b primed=%b required 0/0/0", bus.dout_valid, bus.ovf, bus.primed);
    end
    resetn = 1'b1;
    repeat (4) tick();
  endtask

`ifdef PULSE_SYNC_GC_STATS_EN
  task automatic test_stats();
    bus.dout_ready[2] = 1'b1;
    set_src(2, src_cnt[2] + 5);
    repeat (10) tick();
    vectors++;
    if (bus.stat_cnt[2] !== 32'd5) begin
      miscompares++;
      $display("FAIL stat_count: stat_cnt[2]=%0d required 5", bus.stat_cnt[2]);
    end
    set_src(2, src_cnt[2] + 2);
    repeat (3) tick();
    bus.stat_clr = 1'b1;  // a take happens on this edge too
    tick();
    bus.stat_clr = 1'b0;
    vectors++;
    if (bus.stat_cnt[2] !== 32'd0) begin
      miscompares++;
      $display("FAIL stat_clr_take: stat_cnt[2]=%0d required 0", bus.stat_cnt[2]);
    end
    tick();
    vectors++;
    if (bus.stat_cnt[2] !== 32'd1) begin
      miscompares++;
      $display("FAIL stat_after_clr: stat_cnt[2]=%0d required 1", bus.stat_cnt[2]);
    end
    bus.dout_ready[2] = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      resetn = !(cyc >= 400 && cyc < 402);
      for (int c = 0; c < NC; c++) begin
        set_src(c, src_cnt[c] + (($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 2)));
        bus.dout_ready[c] = ($urandom_range(0, 3) != 0);
        bus.ovf_clr[c] = ($urandom_range(0, 7) == 0);
      end
`ifdef PULSE_SYNC_GC_STATS_EN
      bus.stat_clr = ($urandom_range(0, 31) == 0);
`endif
      tick();
      vectors++;
      if (bus.primed !== (n_edges >= SS + 1)) begin
        miscompares++;
        $display("FAIL rand_primed cyc %0d: primed=%b required %b", cyc, bus.primed, (n_edges >= SS + 1));
      end
      for (int c = 0; c < NC; c++) begin
        vectors++;
        if (bus.dout_valid[c] !== (m_backlog[c] != 0) || bus.ovf[c] !== m_ovf[c]) begin
          miscompares++;
          $display("FAIL rand cyc %0d ch%0d: valid=%b ovf=%b required valid=%b ovf=%b",
                   cyc, c, bus.dout_valid[c], bus.ovf[c], (m_backlog[c] != 0), m_ovf[c]);
        end
`ifdef PULSE_SYNC_GC_STATS_EN
        vectors++;
        if (bus.stat_cnt[c] !== 32'(m_stat[c])) begin
          miscompares++;
          $display("FAIL rand_stat cyc %0d ch%0d: stat_cnt=%0d required %0d", cyc, c, bus.stat_cnt[c], m_stat[c]);
        end
`endif
      end
    end
    bus.dout_ready = '0;
    bus.ovf_clr = '0;
`ifdef PULSE_SYNC_GC_STATS_EN
    bus.stat_clr = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_burst();
    test_wrap_backpressure();
    test_overflow();
    test_simultaneous();
`ifdef PULSE_SYNC_GC_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
